// File: rtl/controlador_senha_pkg.sv
// Shared types and constants for the combination-lock controller:
// state encodings, digit width and the power-on code.
package controlador_senha_pkg;

   localparam int LARG_DIGITO = 4;
   localparam int MAX_DIGITOS = 8;

   typedef enum logic [2:0] {
      VERIFICA  = 3'd0,
      ABERTO    = 3'd1,
      PROGRAMA  = 3'd2,
      BLOQUEADO = 3'd3
   } estado_t;

   localparam logic [LARG_DIGITO-1:0] CODIGO_PADRAO [6] = '{4'd5, 4'd9, 4'd0, 4'd2, 4'd8, 4'd1};

   // Positions beyond the six-digit default come up as zero.
   function automatic logic [LARG_DIGITO-1:0] digito_padrao(input logic [2:0] pos);
      if (pos < 3'd6) return CODIGO_PADRAO[pos];
      return '0;
   endfunction

endpackage

// File: rtl/controlador_senha_detector_borda.sv
// Rising-edge detector: one-cycle pulse when the input goes from 0 to 1.
module detector_borda (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic in_q;

   always_ff @(posedge clk) begin
      if (reset) in_q <= 1'b0;
      else       in_q <= in;
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/controlador_senha.sv
// Combination-lock sequencer: checks entered digits against a programmable
// code, counts wrong digits, enforces a timed lockout and allows reprogramming.
//
// state     | meaning
// VERIFICA  | comparing entered digits against the stored code
// ABERTO    | code accepted; lock open, reprogramming may be requested
// PROGRAMA  | writing a new code one digit per event
// BLOQUEADO | too many wrong digits; timed lockout, inputs ignored
module controlador_senha
   import controlador_senha_pkg::*;
#(
   parameter int N_DIGITOS      = 6,
   parameter int MAX_ERROS      = 1,
   parameter int LOCKOUT_CICLOS = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       insere,
   input  logic       programa,
   input  logic [3:0] numero,
   output logic [2:0] estado_out,
   output logic [2:0] indice,
   output logic [3:0] digito,
   output logic       LED,
   output logic       aberto,
   output logic       bloqueado,
   output logic       invalido
);

   localparam int EW = (MAX_ERROS > 0) ? $clog2(MAX_ERROS + 1) : 1;
   localparam int CW = $clog2(LOCKOUT_CICLOS + 1);

   localparam logic [2:0]    ULTIMO = 3'(N_DIGITOS - 1);
   localparam logic [EW-1:0] MAX_E  = EW'(MAX_ERROS);
   localparam logic [CW-1:0] CARGA  = CW'(LOCKOUT_CICLOS - 1);

   estado_t                estado;
   logic [EW-1:0]          erros;
   logic [CW-1:0]          contador;
   logic [LARG_DIGITO-1:0] codigo [MAX_DIGITOS];
   logic                   ev;

   detector_borda u_borda (
      .clk   (clk),
      .reset (reset),
      .in    (insere),
      .pulse (ev)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= VERIFICA;
         indice   <= '0;
         erros    <= '0;
         digito   <= '0;
         LED      <= 1'b0;
         invalido <= 1'b0;
         contador <= '0;
         for (int i = 0; i < MAX_DIGITOS; i++) codigo[i] <= digito_padrao(3'(i));
      end else begin
         invalido <= 1'b0;
         if (ev) digito <= numero;

         case (estado)
            VERIFICA: begin
               if (ev) begin
                  if (numero == codigo[indice]) begin
                     if (indice == ULTIMO) begin
                        estado <= ABERTO;
                        indice <= '0;
                     end else begin
                        indice <= indice + 3'd1;
                     end
                  end else if (erros < MAX_E) begin
                     // Retry the same position; the LED shows an error was spent.
                     erros <= erros + EW'(1);
                     LED   <= 1'b1;
                  end else begin
                     estado   <= BLOQUEADO;
                     contador <= CARGA;
                  end
               end
            end

            BLOQUEADO: begin
               if (contador == '0) begin
                  estado <= VERIFICA;
                  indice <= '0;
                  erros  <= '0;
                  LED    <= 1'b0;
               end else begin
                  contador <= contador - CW'(1);
               end
            end

            ABERTO: begin
               if (programa) begin
                  estado <= PROGRAMA;
                  indice <= '0;
               end else if (ev) begin
                  estado <= VERIFICA;
                  indice <= '0;
                  erros  <= '0;
                  LED    <= 1'b0;
               end
            end

            PROGRAMA: begin
               if (ev) begin
                  if (numero <= 4'd9) begin
                     codigo[indice] <= numero;
                     if (indice == ULTIMO) begin
                        estado <= VERIFICA;
                        indice <= '0;
                        erros  <= '0;
                        LED    <= 1'b0;
                     end else begin
                        indice <= indice + 3'd1;
                     end
                  end else begin
                     invalido <= 1'b1;
                  end
               end
            end

            default: begin
               estado <= VERIFICA;
               indice <= '0;
               erros  <= '0;
               LED    <= 1'b0;
            end
         endcase
      end
   end

   assign estado_out = estado;
   assign aberto     = (estado == ABERTO);
   assign bloqueado  = (estado == BLOQUEADO);

endmodule

// File: tb/tb_controlador_senha.sv
// Bench for controlador_senha: behavioural lock model checked every cycle,
// plus hand-computed expectations along a directed stimulus script.
module tb_controlador_senha;

   localparam int N   = 6;
   localparam int MAXE = 1;
   localparam int L   = 8;

   logic       clk = 1'b0;
   logic       reset, insere, programa;
   logic [3:0] numero;
   logic [2:0] estado_out, indice;
   logic [3:0] digito;
   logic       LED, aberto, bloqueado, invalido;

   controlador_senha #(.N_DIGITOS(N), .MAX_ERROS(MAXE), .LOCKOUT_CICLOS(L)) dut (
      .clk        (clk),
      .reset      (reset),
      .insere     (insere),
      .programa   (programa),
      .numero     (numero),
      .estado_out (estado_out),
      .indice     (indice),
      .digito     (digito),
      .LED        (LED),
      .aberto     (aberto),
      .bloqueado  (bloqueado),
      .invalido   (invalido)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Model: lock described as states, an error budget, a code array and an
   // absolute release time for the lockout.
   int  m_state, m_idx, m_err, m_led, m_dig, m_inv, m_prev;
   int  m_code [8];
   int  m_release, cyc, inv_cnt;
   bit  m_valid = 0;
   int  dflt [8] = '{5, 9, 0, 2, 8, 1, 0, 0};

   initial begin
      int s_rst, s_ins, s_prog, s_num, ev;
      cyc = 0;
      inv_cnt = 0;
      forever begin
         @(posedge clk);
         s_rst = reset; s_ins = insere; s_prog = programa; s_num = int'(numero);
         cyc++;
         if (s_rst) begin
            m_state = 0; m_idx = 0; m_err = 0; m_led = 0; m_dig = 0; m_inv = 0; m_prev = 0;
            for (int i = 0; i < 8; i++) m_code[i] = dflt[i];
            m_valid = 1;
         end else if (m_valid) begin
            ev = (s_ins == 1 && m_prev == 0) ? 1 : 0;
            m_prev = s_ins;
            m_inv = 0;
            if (ev == 1) m_dig = s_num;
            if (m_state == 0) begin
               if (ev == 1) begin
                  if (s_num == m_code[m_idx]) begin
                     if (m_idx == N - 1) begin m_state = 1; m_idx = 0; end
                     else m_idx = m_idx + 1;
                  end else if (m_err < MAXE) begin
                     m_err = m_err + 1; m_led = 1;
                  end else begin
                     m_state = 3; m_release = cyc + L;
                  end
               end
            end else if (m_state == 3) begin
               if (cyc == m_release) begin m_state = 0; m_idx = 0; m_err = 0; m_led = 0; end
            end else if (m_state == 1) begin
               if (s_prog == 1) begin m_state = 2; m_idx = 0; end
               else if (ev == 1) begin m_state = 0; m_idx = 0; m_err = 0; m_led = 0; end
            end else begin
               if (ev == 1) begin
                  if (s_num <= 9) begin
                     m_code[m_idx] = s_num;
                     if (m_idx == N - 1) begin m_state = 0; m_idx = 0; m_err = 0; m_led = 0; end
                     else m_idx = m_idx + 1;
                  end else m_inv = 1;
               end
            end
         end
         #1;
         if (m_valid) begin
            chk("estado", int'(estado_out), m_state);
            chk("indice", int'(indice), m_idx);
            chk("digito", int'(digito), m_dig);
            chk("LED", int'(LED), m_led);
            chk("aberto", int'(aberto), (m_state == 1) ? 1 : 0);
            chk("bloqueado", int'(bloqueado), (m_state == 3) ? 1 : 0);
            chk("invalido", int'(invalido), m_inv);
            if (invalido) inv_cnt++;
         end
      end
   end

   task automatic press(input int n);
      @(negedge clk);
      numero = 4'(n);
      insere = 1'b1;
      @(negedge clk);
      insere = 1'b0;
   endtask

   task automatic enter(input int d0, d1, d2, d3, d4, d5);
      press(d0); press(d1); press(d2); press(d3); press(d4); press(d5);
   endtask

   task automatic wait_lock_end(input string nm);
      int k;
      k = 0;
      while (bloqueado && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk(nm, int'(bloqueado), 0);
   endtask

   initial begin
      int k;
      int seq2 [7] = '{5, 7, 9, 0, 2, 8, 1};
      reset = 1'b1; insere = 1'b0; programa = 1'b0; numero = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_estado", int'(estado_out), 0);
      chk("rst_indice", int'(indice), 0);
      chk("rst_digito", int'(digito), 0);
      chk("rst_leds", int'({LED, aberto, bloqueado, invalido}), 0);
      reset = 1'b0;

      // Default code opens the lock
      for (int i = 0; i < N; i++) begin
         press(dflt[i]);
         if (i < N - 1) chk("t1_indice", int'(indice), i + 1);
      end
      chk("t1_aberto", int'(aberto), 1);
      chk("t1_LED", int'(LED), 0);
      chk("t1_mdl_state", m_state, 1);
      press(3);
      chk("t1_relock", int'(estado_out), 0);

      // One tolerated error
      for (int i = 0; i < 7; i++) begin
         press(seq2[i]);
         if (i == 1) begin
            chk("t2_LED", int'(LED), 1);
            chk("t2_indice", int'(indice), 1);
         end
      end
      chk("t2_aberto", int'(aberto), 1);
      chk("t2_LED_open", int'(LED), 1);
      press(0);
      chk("t2_relock_LED", int'(LED), 0);

      // Lockout dwell, with an ignored digit inside it
      press(5); press(7); press(3);
      chk("t3_bloq", int'(bloqueado), 1);
      chk("t3_mdl_bloq", m_state, 3);
      press(5);
      k = 2;
      while (bloqueado && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("t3_dwell", k, L);
      chk("t3_estado", int'(estado_out), 0);
      chk("t3_indice", int'(indice), 0);
      chk("t3_LED", int'(LED), 0);

      // Held strobe gives a single event
      @(negedge clk);
      numero = 4'd5; insere = 1'b1;
      repeat (5) @(negedge clk);
      insere = 1'b0;
      @(negedge clk);
      chk("t4_indice", int'(indice), 1);
      chk("t4_digito", int'(digito), 5);
      press(9); press(0); press(2); press(8); press(1);
      chk("t4_aberto", int'(aberto), 1);

      // Reprogram to 1..6 with a rejected digit
      @(negedge clk); programa = 1'b1;
      @(negedge clk); programa = 1'b0;
      chk("t5_programa", int'(estado_out), 2);
      press(1); press(2); press(3); press(12);
      chk("t5_invalido", int'(invalido), 1);
      chk("t5_indice_hold", int'(indice), 3);
      press(4); press(5); press(6);
      chk("t5_verifica", int'(estado_out), 0);
      chk("t5_inv_count", inv_cnt, 1);
      press(5);
      chk("t5_old_LED", int'(LED), 1);
      press(9);
      chk("t5_old_bloq", int'(bloqueado), 1);
      press(0); press(2); press(8); press(1);
      wait_lock_end("t5_lock_end");
      enter(1, 2, 3, 4, 5, 6);
      chk("t5_new_open", int'(aberto), 1);
      chk("t5_mdl_code", m_code[3], 4);

      // Reset during programming restores the default code
      @(negedge clk); programa = 1'b1;
      @(negedge clk); programa = 1'b0;
      press(7); press(7); press(7);
      chk("t6_indice", int'(indice), 3);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("t6_rst_estado", int'(estado_out), 0);
      chk("t6_rst_indice", int'(indice), 0);
      enter(5, 9, 0, 2, 8, 1);
      chk("t6_default_open", int'(aberto), 1);
      chk("t6_mdl_code", m_code[0], 5);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/controlador_senha.md
Name: controlador_senha

Overview:
Sequencing and configuration controller for the 4-bit digit combination-lock datapath. It edge-detects the `insere` strobe and checks entered digits against a programmable N-digit code. It tolerates a bounded number of wrong digits, then enforces a timed lockout. After a successful unlock, it lets the user reprogram the code. It sits between the keypad/switch inputs and the display/LED logic.

Parameters:
- N_DIGITOS, 6: code length in digits (2..8).
- MAX_ERROS, 1: wrong digits tolerated per attempt before lockout.
- LOCKOUT_CICLOS, 1000: clock cycles spent in BLOQUEADO.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- insere, input, 1: digit-entry strobe (level); only its rising edge is an event.
- programa, input, 1: request to enter PROGRAMA; honoured only in ABERTO.
- numero, input, 4: digit value; sampled on an insere event.
- estado_out, output, 3: current state encoding.
- indice, output, 3: digit position 0..N_DIGITOS-1.
- digito, output, 4: numero captured at the last event (for the display).
- LED, output, 1: at least one error used in this attempt.
- aberto, output, 1: high in ABERTO.
- bloqueado, output, 1: high in BLOQUEADO.
- invalido, output, 1: one-cycle pulse on a rejected programming digit.

Behaviour:
- Reset:
  - state = VERIFICA; indice = 0; erros = 0; digito = 0.
  - LED, aberto, bloqueado, invalido = 0.
  - insere history = 0.
  - Code memory restored to the default 5,9,0,2,8,1 (first N_DIGITOS entries).
  - Reset overrides everything, including mid-lockout and mid-programming.
- Event detection:
  - ev = insere & ~insere_q, where insere_q is insere registered on the previous edge.
  - Holding insere high produces exactly one event.
  - Each event is acted on at the same edge at which it is sampled; outputs update after that edge.
  - digito <= numero on every event, in any state.
- VERIFICA, on ev:
  - numero == code[indice]: if indice == N_DIGITOS-1, go to ABERTO and set indice = 0; otherwise indice++.
  - Mismatch with erros < MAX_ERROS: erros++, LED = 1, indice unchanged (retry the same position).
  - Mismatch with erros == MAX_ERROS: go to BLOQUEADO and load lockout counter = LOCKOUT_CICLOS-1.
- BLOQUEADO:
  - Events and programa are ignored.
  - Counter decrements each cycle.
  - At count 0, on the next edge: go to VERIFICA with indice = 0, erros = 0, LED = 0.
  - Dwell is exactly LOCKOUT_CICLOS cycles.
- ABERTO:
  - programa = 1: go to PROGRAMA with indice = 0. Takes priority over a simultaneous ev, which is discarded apart from the digito capture.
  - ev without programa: relock, i.e. go to VERIFICA with indice = 0, erros = 0, LED = 0.
- PROGRAMA, on ev:
  - numero <= 9: code[indice] <= numero; indice++.
  - After writing position N_DIGITOS-1: go to VERIFICA with indice = 0, erros = 0, LED = 0.
  - numero > 9: no write, indice unchanged, invalido pulses for one cycle.
- Cross-cutting rules:
  - In VERIFICA, a numero value > 9 is simply a mismatch.
  - LOCKOUT counter width is $clog2(LOCKOUT_CICLOS+1).
  - erros width is $clog2(MAX_ERROS+1).
  - Unused state encodings recover to VERIFICA on the next edge with indice = 0 and erros = 0.

Decomposition:
- Package controlador_senha_pkg holds:
  - State encodings: VERIFICA = 0, ABERTO = 1, PROGRAMA = 2, BLOQUEADO = 3.
  - The default code constant (5,9,0,2,8,1).
  - The digit width constant (4).
- One sub-module, detector_borda: ports clk, reset, in; output pulse; registered previous value, rising-edge pulse.
- Code memory and FSM stay in controlador_senha.

Test Plan (LOCKOUT_CICLOS = 8, MAX_ERROS = 1, N_DIGITOS = 6):
- Reset, then enter 5,9,0,2,8,1 (one edge each) → indice steps 0..5; aberto = 1 after the 6th event; LED = 0.
- Enter 5, 7, 9, 0, 2, 8, 1 → after 7: LED = 1, indice stays 1; then ABERTO is reached with LED = 1.
- Enter 5, 7, 3 → BLOQUEADO after 3; a 4th edge during lockout has no effect; VERIFICA returns exactly 8 cycles later with indice = 0, LED = 0.
- Hold insere high for 5 cycles with numero = 5 → exactly one event; indice = 1.
- From ABERTO:
  - Pulse programa, then enter 1,2,3,12,4,5,6 → invalido pulses once on 12.
  - State returns to VERIFICA after 6 valid digits.
  - Entering 5,9,0,2,8,1 now goes to LED = 1 then BLOQUEADO.
  - Entering 1,2,3,4,5,6 opens the lock.
- Assert reset mid-PROGRAMA after 3 digits → default code is restored; 5,9,0,2,8,1 opens the lock.
